// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU opcodes, DataSrc encodings, widths and control bundle
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int RID_W  = 4;

  localparam logic [3:0] OP_LW  = 4'b1000;
  localparam logic [3:0] OP_SW  = 4'b1001;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [1:0] {
    DS_MEM = 2'b00,
    DS_PC  = 2'b01,
    DS_IMM = 2'b10,
    DS_ALU = 2'b11
  } datasrc_e;

  typedef struct packed {
    logic     regwrite;
    logic     memop;
    logic     memwrite;
    logic     alusrc;
    datasrc_e datasrc;
    logic     hlt;
  } ctrl_t;

  function automatic logic is_load(input logic memop, input logic memwrite);
    return memop & ~memwrite;
  endfunction

  // A bubble only needs the side-effecting bits cleared; mux selects may stay stale.
  function automatic ctrl_t bubble_ctrl(input ctrl_t c);
    ctrl_t b;
    b          = c;
    b.regwrite = 1'b0;
    b.memop    = 1'b0;
    b.memwrite = 1'b0;
    b.hlt      = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - ID-side decoded fields in, EX-side registered fields out
interface id_ex_stage_if #(
  parameter int DATA_W = 16,
  parameter int RID_W  = 4
);
  logic              id_RegWrite;
  logic              id_MemOp;
  logic              id_MemWrite;
  logic              id_ALUSrc;
  logic [1:0]        id_DataSrc;
  logic              id_hlt;
  logic [3:0]        id_opcode;
  logic [RID_W-1:0]  id_rs;
  logic [RID_W-1:0]  id_rt;
  logic [RID_W-1:0]  id_rd;
  logic              id_rs_used;
  logic              id_rt_used;
  logic [DATA_W-1:0] id_rd1;
  logic [DATA_W-1:0] id_rd2;
  logic [DATA_W-1:0] id_imm;
  logic [DATA_W-1:0] id_pc;

  logic              ex_RegWrite;
  logic              ex_MemOp;
  logic              ex_MemWrite;
  logic              ex_ALUSrc;
  logic [1:0]        ex_DataSrc;
  logic              ex_hlt;
  logic [3:0]        ex_opcode;
  logic [RID_W-1:0]  ex_rs;
  logic [RID_W-1:0]  ex_rt;
  logic [RID_W-1:0]  ex_rd;
  logic [DATA_W-1:0] ex_rd1;
  logic [DATA_W-1:0] ex_rd2;
  logic [DATA_W-1:0] ex_imm;
  logic [DATA_W-1:0] ex_pc;
  logic              ex_valid;

  modport master (
    output id_RegWrite, id_MemOp, id_MemWrite, id_ALUSrc, id_DataSrc, id_hlt,
           id_opcode, id_rs, id_rt, id_rd, id_rs_used, id_rt_used,
           id_rd1, id_rd2, id_imm, id_pc,
    input  ex_RegWrite, ex_MemOp, ex_MemWrite, ex_ALUSrc, ex_DataSrc, ex_hlt,
           ex_opcode, ex_rs, ex_rt, ex_rd, ex_rd1, ex_rd2, ex_imm, ex_pc, ex_valid
  );

  modport slave (
    input  id_RegWrite, id_MemOp, id_MemWrite, id_ALUSrc, id_DataSrc, id_hlt,
           id_opcode, id_rs, id_rt, id_rd, id_rs_used, id_rt_used,
           id_rd1, id_rd2, id_imm, id_pc,
    output ex_RegWrite, ex_MemOp, ex_MemWrite, ex_ALUSrc, ex_DataSrc, ex_hlt,
           ex_opcode, ex_rs, ex_rt, ex_rd, ex_rd1, ex_rd2, ex_imm, ex_pc, ex_valid
  );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// rtl/id_ex_stage_hazard_detect.sv - combinational load-use compare between EX and ID
module hazard_detect #(
  parameter int RID_W = 4
) (
  input  logic             ex_valid,
  input  logic             ex_memop,
  input  logic             ex_memwrite,
  input  logic [RID_W-1:0] ex_rd,
  input  logic [RID_W-1:0] id_rs,
  input  logic [RID_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  output logic             hazard
);
  import cpu_pkg::*;

  logic load_in_ex;
  logic rs_match;
  logic rt_match;

  // Register 0 is hardwired zero, so a load targeting it never produces a dependency.
  assign load_in_ex = ex_valid & is_load(ex_memop, ex_memwrite) & (ex_rd != '0);
  assign rs_match   = id_rs_used & (id_rs == ex_rd);
  assign rt_match   = id_rt_used & (id_rt == ex_rd);
  assign hazard     = load_in_ex & (rs_match | rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble, halt latch and bubble counter
module id_ex_stage #(
  parameter int DATA_W = 16,
  parameter int RID_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_in,
  input  logic             flush_in,
  id_ex_stage_if.slave     bus,
  output logic             hazard_stall,
  output logic             halted,
  output logic [CNT_W-1:0] lu_count
);
  import cpu_pkg::*;

  logic              ex_valid_q;
  logic              halted_q;
  ctrl_t             ctrl_q;
  ctrl_t             id_ctrl;
  logic [3:0]        op_q;
  logic [RID_W-1:0]  rs_q;
  logic [RID_W-1:0]  rt_q;
  logic [RID_W-1:0]  rd_q;
  logic [DATA_W-1:0] rd1_q;
  logic [DATA_W-1:0] rd2_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] pc_q;
  logic [CNT_W-1:0]  lu_q;

  logic hazard;
  logic halt_now;
  logic take_bubble;
  logic lu_inc;

  hazard_detect #(.RID_W(RID_W)) u_hazard_detect (
    .ex_valid    (ex_valid_q),
    .ex_memop    (ctrl_q.memop),
    .ex_memwrite (ctrl_q.memwrite),
    .ex_rd       (rd_q),
    .id_rs       (bus.id_rs),
    .id_rt       (bus.id_rt),
    .id_rs_used  (bus.id_rs_used),
    .id_rt_used  (bus.id_rt_used),
    .hazard      (hazard)
  );

  assign id_ctrl.regwrite = bus.id_RegWrite;
  assign id_ctrl.memop    = bus.id_MemOp;
  assign id_ctrl.memwrite = bus.id_MemWrite;
  assign id_ctrl.alusrc   = bus.id_ALUSrc;
  assign id_ctrl.datasrc  = datasrc_e'(bus.id_DataSrc);
  assign id_ctrl.hlt      = bus.id_hlt;

  // The instruction behind a valid HLT is already younger, so it is squashed
  // on the same edge that sets the sticky flag.
  assign halt_now     = halted_q | (ex_valid_q & ctrl_q.hlt);
  assign take_bubble  = halt_now | hazard | flush_in;
  assign lu_inc       = ~halt_now & hazard & (lu_q != {CNT_W{1'b1}});
  assign hazard_stall = hazard & ~halted_q & ~stall_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      ctrl_q     <= '0;
      op_q       <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
      lu_q       <= '0;
    end else if (!stall_in) begin
      halted_q <= halt_now;
      if (take_bubble) begin
        ex_valid_q <= 1'b0;
        ctrl_q     <= bubble_ctrl(ctrl_q);
      end else begin
        ex_valid_q <= 1'b1;
        ctrl_q     <= id_ctrl;
        op_q       <= bus.id_opcode;
        rs_q       <= bus.id_rs;
        rt_q       <= bus.id_rt;
        rd_q       <= bus.id_rd;
        rd1_q      <= bus.id_rd1;
        rd2_q      <= bus.id_rd2;
        imm_q      <= bus.id_imm;
        pc_q       <= bus.id_pc;
      end
      if (lu_inc) begin
        lu_q <= lu_q + 1'b1;
      end
    end
  end

  assign bus.ex_valid    = ex_valid_q;
  assign bus.ex_RegWrite = ctrl_q.regwrite;
  assign bus.ex_MemOp    = ctrl_q.memop;
  assign bus.ex_MemWrite = ctrl_q.memwrite;
  assign bus.ex_ALUSrc   = ctrl_q.alusrc;
  assign bus.ex_DataSrc  = ctrl_q.datasrc;
  assign bus.ex_hlt      = ctrl_q.hlt;
  assign bus.ex_opcode   = op_q;
  assign bus.ex_rs       = rs_q;
  assign bus.ex_rt       = rt_q;
  assign bus.ex_rd       = rd_q;
  assign bus.ex_rd1      = rd1_q;
  assign bus.ex_rd2      = rd2_q;
  assign bus.ex_imm      = imm_q;
  assign bus.ex_pc       = pc_q;

  assign halted   = halted_q;
  assign lu_count = lu_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - randomized and directed bench for id_ex_stage against a slot-level model
module tb_id_ex_stage;
  import cpu_pkg::*;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_LLB = 4'b1010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_in = 1'b0;
  logic        flush_in = 1'b0;
  logic        hazard_stall, halted, hazard_stall2, halted2;
  logic [15:0] lu_count;
  logic [1:0]  lu_count2;

  int total = 0;
  int bad = 0;

  id_ex_stage_if #(.DATA_W(16), .RID_W(4)) io ();
  id_ex_stage_if #(.DATA_W(16), .RID_W(4)) io2 ();

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(16), .RID_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .flush_in(flush_in),
    .bus(io.slave), .hazard_stall(hazard_stall), .halted(halted), .lu_count(lu_count)
  );

  // Narrow-counter copy fed the same stream, so saturation is reachable in a short run.
  id_ex_stage #(.DATA_W(16), .RID_W(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .flush_in(flush_in),
    .bus(io2.slave), .hazard_stall(hazard_stall2), .halted(halted2), .lu_count(lu_count2)
  );

  assign io2.id_RegWrite = io.id_RegWrite;
  assign io2.id_MemOp    = io.id_MemOp;
  assign io2.id_MemWrite = io.id_MemWrite;
  assign io2.id_ALUSrc   = io.id_ALUSrc;
  assign io2.id_DataSrc  = io.id_DataSrc;
  assign io2.id_hlt      = io.id_hlt;
  assign io2.id_opcode   = io.id_opcode;
  assign io2.id_rs       = io.id_rs;
  assign io2.id_rt       = io.id_rt;
  assign io2.id_rd       = io.id_rd;
  assign io2.id_rs_used  = io.id_rs_used;
  assign io2.id_rt_used  = io.id_rt_used;
  assign io2.id_rd1      = io.id_rd1;
  assign io2.id_rd2      = io.id_rd2;
  assign io2.id_imm      = io.id_imm;
  assign io2.id_pc       = io.id_pc;

  typedef struct {
    bit          v, rw, mo, mw, as, h;
    bit [1:0]    ds;
    bit [3:0]    op, rs, rt, rd;
    bit [15:0]   r1, r2, imm, pc;
  } slot_t;

  slot_t m;
  bit    m_halted;
  int    m_cnt, m_cnt2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_hazard();
    bit dep;
    dep = (io.id_rs_used && io.id_rs == m.rd) || (io.id_rt_used && io.id_rt == m.rd);
    return m.v && m.mo && !m.mw && m.rd != 0 && dep;
  endfunction

  task automatic model_reset();
    m = '{default: 0};
    m_halted = 0;
    m_cnt = 0;
    m_cnt2 = 0;
  endtask

  // One rising edge, following the stated priority list.
  task automatic model_edge();
    bit halt_now, hz;
    if (!rst_n || stall_in) return;
    halt_now = m_halted || (m.v && m.h);
    hz = m_hazard();
    if (!halt_now && hz) begin
      m_cnt  = (m_cnt  < 65535) ? m_cnt  + 1 : 65535;
      m_cnt2 = (m_cnt2 < 3)     ? m_cnt2 + 1 : 3;
    end
    if (halt_now || hz || flush_in) begin
      m.v = 0; m.rw = 0; m.mo = 0; m.mw = 0; m.h = 0;
    end else begin
      m.v = 1; m.rw = io.id_RegWrite; m.mo = io.id_MemOp; m.mw = io.id_MemWrite;
      m.as = io.id_ALUSrc; m.ds = io.id_DataSrc; m.h = io.id_hlt; m.op = io.id_opcode;
      m.rs = io.id_rs; m.rt = io.id_rt; m.rd = io.id_rd;
      m.r1 = io.id_rd1; m.r2 = io.id_rd2; m.imm = io.id_imm; m.pc = io.id_pc;
    end
    m_halted = halt_now;
  endtask

  task automatic check_state();
    chk("ex_valid", io.ex_valid, m.v);
    chk("ex_RegWrite", io.ex_RegWrite, m.rw);
    chk("ex_MemOp", io.ex_MemOp, m.mo);
    chk("ex_MemWrite", io.ex_MemWrite, m.mw);
    chk("ex_hlt", io.ex_hlt, m.h);
    chk("halted", halted, m_halted);
    chk("lu_count", lu_count, m_cnt);
    chk("lu_count_narrow", lu_count2, m_cnt2);
    if (m.v) begin
      chk("ex_ALUSrc", io.ex_ALUSrc, m.as);
      chk("ex_DataSrc", io.ex_DataSrc, m.ds);
      chk("ex_opcode", io.ex_opcode, m.op);
      chk("ex_rs", io.ex_rs, m.rs);
      chk("ex_rt", io.ex_rt, m.rt);
      chk("ex_rd", io.ex_rd, m.rd);
      chk("ex_rd1", io.ex_rd1, m.r1);
      chk("ex_rd2", io.ex_rd2, m.r2);
      chk("ex_imm", io.ex_imm, m.imm);
      chk("ex_pc", io.ex_pc, m.pc);
    end
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic cycle();
    #1;
    chk("hazard_stall", hazard_stall, m_hazard() && !m_halted && !stall_in);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_state();
  endtask

  task automatic instr(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                       input logic [3:0] rt, input logic rsu, input logic rtu);
    io.id_opcode = op; io.id_rd = rd; io.id_rs = rs; io.id_rt = rt;
    io.id_rs_used = rsu; io.id_rt_used = rtu;
    io.id_RegWrite = 1'b1; io.id_MemOp = 1'b0; io.id_MemWrite = 1'b0;
    io.id_ALUSrc = 1'b0; io.id_DataSrc = DS_ALU; io.id_hlt = 1'b0;
    case (op)
      OP_LW:   begin io.id_MemOp = 1'b1; io.id_ALUSrc = 1'b1; io.id_DataSrc = DS_MEM; end
      OP_SW:   begin io.id_RegWrite = 1'b0; io.id_MemOp = 1'b1; io.id_MemWrite = 1'b1; io.id_ALUSrc = 1'b1; end
      OP_LLB:  io.id_DataSrc = DS_IMM;
      OP_HLT:  begin io.id_RegWrite = 1'b0; io.id_hlt = 1'b1; end
      default: ;
    endcase
    io.id_rd1 = 16'($urandom); io.id_rd2 = 16'($urandom);
    io.id_imm = 16'($urandom); io.id_pc = 16'($urandom);
  endtask

  task automatic random_instr();
    logic [3:0] op;
    case ($urandom_range(0, 9))
      0, 1, 2: op = OP_LW;
      3:       op = OP_SW;
      4:       op = OP_LLB;
      9:       op = ($urandom_range(0, 40) == 0) ? OP_HLT : OP_SUB;
      default: op = 4'($urandom_range(0, 7));
    endcase
    instr(op, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    model_reset();
    instr(OP_ADD, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_state();
    @(negedge clk);
    rst_n = 1'b1;

    // Load then dependent ADD: one stall cycle, one bubble, then ADD.
    instr(OP_LW, 3, 1, 0, 1, 0); cycle();
    instr(OP_ADD, 4, 3, 5, 1, 1);
    #1 chk("t2_stall_on", hazard_stall, 1'b1);
    cycle();
    chk("t2_bubble", io.ex_valid, 1'b0);
    #1 chk("t2_stall_off", hazard_stall, 1'b0);
    cycle();
    chk("t2_add_in_ex", io.ex_opcode, OP_ADD);
    chk("t2_add_valid", io.ex_valid, 1'b1);
    chk("t2_lu", lu_count, 16'd1);

    // Register 0 and unused sources never stall.
    instr(OP_LW, 0, 1, 0, 1, 0); cycle();
    instr(OP_ADD, 4, 0, 5, 1, 1);
    #1 chk("t3_r0_nostall", hazard_stall, 1'b0);
    cycle();
    instr(OP_LW, 3, 1, 0, 1, 0); cycle();
    instr(OP_LLB, 3, 3, 3, 0, 0);
    #1 chk("t3_unused_nostall", hazard_stall, 1'b0);
    cycle();

    // Hazard under a memory stall: everything frozen, no hazard_stall.
    instr(OP_LW, 3, 1, 0, 1, 0); cycle();
    instr(OP_ADD, 4, 3, 5, 1, 1);
    stall_in = 1'b1;
    repeat (3) begin
      cycle();
      chk("t4_held_op", io.ex_opcode, OP_LW);
      chk("t4_held_valid", io.ex_valid, 1'b1);
    end
    stall_in = 1'b0;
    #1 chk("t4_stall_after", hazard_stall, 1'b1);
    cycle(); cycle();
    chk("t4_add_in_ex", io.ex_opcode, OP_ADD);

    // Flush alone, then flush coinciding with a hazard.
    instr(OP_ADD, 6, 1, 2, 1, 1); flush_in = 1'b1; cycle();
    chk("t5_flush_valid", io.ex_valid, 1'b0);
    chk("t5_flush_rw", io.ex_RegWrite, 1'b0);
    flush_in = 1'b0;
    instr(OP_LW, 3, 1, 0, 1, 0); cycle();
    instr(OP_ADD, 4, 3, 5, 1, 1); flush_in = 1'b1; cycle();
    chk("t5_flush_hz_valid", io.ex_valid, 1'b0);
    chk("t5_flush_hz_lu", lu_count, 16'd3);
    flush_in = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      random_instr();
      stall_in = ($urandom_range(0, 5) == 0);
      flush_in = ($urandom_range(0, 7) == 0);
      cycle();
    end
    stall_in = 1'b0;
    flush_in = 1'b0;

    // Asynchronous reset between edges clears outputs with no clock edge.
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_state();
    chk("t1_ex_rd1", io.ex_rd1, 16'd0);
    chk("t1_ex_pc", io.ex_pc, 16'd0);
    chk("t1_ex_opcode", io.ex_opcode, 4'd0);
    chk("t1_ex_rd", io.ex_rd, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Narrow counter saturates at 3 while the wide one keeps counting.
    for (int i = 0; i < 5; i++) begin
      instr(OP_LW, 3, 1, 0, 1, 0); cycle();
      instr(OP_ADD, 4, 3, 5, 1, 1); cycle();
    end
    chk("t6_sat_narrow", lu_count2, 2'd3);
    chk("t6_wide_count", lu_count, 16'd5);

    // HLT passes through, everything after it is a bubble.
    instr(OP_HLT, 0, 0, 0, 0, 0); cycle();
    chk("t6_hlt_in_ex", io.ex_hlt, 1'b1);
    chk("t6_hlt_valid", io.ex_valid, 1'b1);
    chk("t6_not_yet_halted", halted, 1'b0);
    instr(OP_ADD, 4, 1, 2, 1, 1); cycle();
    chk("t6_halted", halted, 1'b1);
    chk("t6_add_bubble", io.ex_valid, 1'b0);
    instr(OP_SUB, 5, 1, 2, 1, 1); cycle();
    chk("t6_sub_bubble", io.ex_valid, 1'b0);
    chk("t6_still_halted", halted, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
